// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-lite encodings (HTRANS, HRESP) and the state
//                enumeration of the built-in default slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // A transfer carries a data phase only for NONSEQ and SEQ.
  function automatic logic htrans_active(input logic [1:0] t);
    logic r;
    case (t)
      HTRANS_IDLE:   r = 1'b0;
      HTRANS_BUSY:   r = 1'b0;
      HTRANS_NONSEQ: r = 1'b1;
      HTRANS_SEQ:    r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_decode_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_decode_mux_if
//  Description : Bus bundle between the AHB-lite master, the decoder/mux and
//                the slaves.
//                Master side : htrans, haddr, hwrite, hwdata -> ;
//                              <- hrdata, hresp, hready, err_cnt
//                Slave side  : hsel_o, haddr_o, hwrite_o, hwdata_o,
//                              hready_o -> ; <- hrdata_s, hresp_s, hready_s
//                Modport 'slave' is the decoder view, 'master' the
//                environment (master + slaves) view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_decode_mux_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
);

  logic [1:0]                 htrans;
  logic [ADDR_W-1:0]          haddr;
  logic                       hwrite;
  logic [DATA_W-1:0]          hwdata;

  logic [NUM_SLAVES-1:0]      hsel_o;
  logic [ADDR_W-1:0]          haddr_o;
  logic                       hwrite_o;
  logic [DATA_W-1:0]          hwdata_o;
  logic                       hready_o;

  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
  logic [NUM_SLAVES*2-1:0]      hresp_s;
  logic [NUM_SLAVES-1:0]        hready_s;

  logic [DATA_W-1:0]          hrdata;
  logic [1:0]                 hresp;
  logic                       hready;
  logic [7:0]                 err_cnt;

  modport slave (
    input  htrans, haddr, hwrite, hwdata, hrdata_s, hresp_s, hready_s,
    output hsel_o, haddr_o, hwrite_o, hwdata_o, hready_o,
           hrdata, hresp, hready, err_cnt
  );

  modport master (
    output htrans, haddr, hwrite, hwdata, hrdata_s, hresp_s, hready_s,
    input  hsel_o, haddr_o, hwrite_o, hwdata_o, hready_o,
           hrdata, hresp, hready, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_default_slave
//  Description : Default slave for unmapped regions. Answers every accepted
//                active transfer with the two-cycle AHB ERROR response.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                accept_i      - active unmapped transfer accepted this edge
//                hready_o      - ready for the unmapped data phase
//                hresp_o       - response for the unmapped data phase
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_default_slave
  import ahb_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       accept_i,
  output logic            hready_o,
  output logic [1:0]      hresp_o
);

  ds_state_e state_q;
  ds_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (accept_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 completes with hready high, so a following unmapped transfer
      // may be accepted on the same edge and restarts the sequence.
      DS_ERR2: state_d = accept_i ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
      end
      DS_ERR2: begin
        hready_o = 1'b1;
        hresp_o  = HRESP_ERROR;
      end
      default: begin
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahb_decode_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_decode_mux
//  Description : AHB-lite address decoder and read-return multiplexer for one
//                master and NUM_SLAVES slaves, with a built-in default slave
//                for unmapped regions and a saturating ERROR counter.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - ahb_decode_mux_if.slave (master and slave sides)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SEL_BITS   = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ahb_decode_mux_if.slave  bus
);

  localparam logic [31:0] C_NUM_SLAVES = NUM_SLAVES;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [SEL_BITS-1:0]   w_idx;
  logic [31:0]           w_idx32;
  logic                  w_mapped;
  logic                  w_active;
  logic [NUM_SLAVES-1:0] w_hsel;

  assign w_idx    = bus.haddr[ADDR_W-1 -: SEL_BITS];
  assign w_idx32  = {{(32-SEL_BITS){1'b0}}, w_idx};
  assign w_mapped = (w_idx32 < C_NUM_SLAVES);
  assign w_active = htrans_active(bus.htrans);

  generate
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_sel
      assign w_hsel[k] = ~rst & w_mapped & (w_idx32 == k);
    end
  endgenerate

  assign bus.hsel_o   = w_hsel;
  assign bus.haddr_o  = bus.haddr;
  assign bus.hwrite_o = bus.hwrite;
  assign bus.hwdata_o = bus.hwdata;

  // --------------------------------------------------------------------------
  // Data-phase select register
  // --------------------------------------------------------------------------
  logic [SEL_BITS-1:0] didx_q, didx_d;
  logic                dvalid_q, dvalid_d;
  logic                ddef_q, ddef_d;

  logic                w_hready;
  logic [1:0]          w_hresp;
  logic [DATA_W-1:0]   w_hrdata;

  always_comb begin
    didx_d   = didx_q;
    dvalid_d = dvalid_q;
    ddef_d   = ddef_q;
    if (w_hready) begin
      didx_d   = w_idx;
      dvalid_d = w_active;
      // ddef only marks a real data phase owned by the default slave;
      // idle/busy transfers to unmapped space fall into the dvalid=0 path.
      ddef_d   = w_active & ~w_mapped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      ddef_q   <= 1'b0;
    end else begin
      didx_q   <= didx_d;
      dvalid_q <= dvalid_d;
      ddef_q   <= ddef_d;
    end
  end

  // --------------------------------------------------------------------------
  // Default slave
  // --------------------------------------------------------------------------
  logic       w_ds_accept;
  logic       w_ds_hready;
  logic [1:0] w_ds_hresp;

  assign w_ds_accept = w_hready & w_active & ~w_mapped;

  ahb_default_slave u_default_slave (
    .clk      (clk),
    .rst      (rst),
    .accept_i (w_ds_accept),
    .hready_o (w_ds_hready),
    .hresp_o  (w_ds_hresp)
  );

  // --------------------------------------------------------------------------
  // Return mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    w_hrdata = '0;
    if (ddef_q) begin
      w_hready = w_ds_hready;
      w_hresp  = w_ds_hresp;
    end else if (dvalid_q) begin
      // Compare against each mapped index so an out-of-range didx can never
      // produce an out-of-range slice.
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (didx_q == SEL_BITS'(k)) begin
          w_hready = bus.hready_s[k];
          w_hresp  = bus.hresp_s[k*2 +: 2];
          w_hrdata = bus.hrdata_s[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.hready   = w_hready;
  assign bus.hready_o = w_hready;
  assign bus.hresp    = w_hresp;
  assign bus.hrdata   = w_hrdata;

  // --------------------------------------------------------------------------
  // Saturating ERROR counter: one count per completed ERROR data phase
  // --------------------------------------------------------------------------
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_hready && (w_hresp == HRESP_ERROR) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_decode_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_decode_mux
//  Description : Scoreboard bench for ahb_decode_mux. The driver applies one
//                directed vector per cycle and queues the hand-computed
//                response; the monitor pops and compares at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_decode_mux;

  localparam int NUM_SLAVES = 3;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int SEL_BITS   = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic clk;
  logic rst;

  ahb_decode_mux_if #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) bus ();

  ahb_decode_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SEL_BITS   (SEL_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  hsel;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [7:0]  err;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic bad;
      e   = sbq.pop_front();
      bad = 1'b0;
      n_vec++;
      if (bus.hsel_o !== e.hsel) begin
        $display("FAIL %s hsel_o: got %b exp %b", e.name, bus.hsel_o, e.hsel); bad = 1'b1;
      end
      if (bus.hready !== e.hready || bus.hready_o !== e.hready) begin
        $display("FAIL %s hready: got %b/%b exp %b", e.name, bus.hready, bus.hready_o, e.hready); bad = 1'b1;
      end
      if (bus.hresp !== e.hresp) begin
        $display("FAIL %s hresp: got %b exp %b", e.name, bus.hresp, e.hresp); bad = 1'b1;
      end
      if (bus.hrdata !== e.hrdata) begin
        $display("FAIL %s hrdata: got %h exp %h", e.name, bus.hrdata, e.hrdata); bad = 1'b1;
      end
      if (bus.err_cnt !== e.err) begin
        $display("FAIL %s err_cnt: got %0d exp %0d", e.name, bus.err_cnt, e.err); bad = 1'b1;
      end
      if (bus.haddr_o !== e.addr || bus.hwrite_o !== e.wr || bus.hwdata_o !== e.wdata) begin
        $display("FAIL %s forward: got %h/%b/%h exp %h/%b/%h", e.name,
                 bus.haddr_o, bus.hwrite_o, bus.hwdata_o, e.addr, e.wr, e.wdata);
        bad = 1'b1;
      end
      if (bad) n_bad++;
    end
  end

  // Apply one address-phase vector for one cycle and queue its expectation.
  task automatic vec(input string nm, input logic [1:0] tr, input logic [15:0] a,
                     input logic [2:0] esel, input logic erdy, input logic [1:0] eresp,
                     input logic [31:0] edat, input logic [7:0] eerr);
    exp_t e;
    bus.htrans = tr;
    bus.haddr  = a;
    bus.hwrite = 1'($urandom_range(0, 1));
    bus.hwdata = $urandom;
    e = '{nm, esel, erdy, eresp, edat, eerr, a, bus.hwrite, bus.hwdata};
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'hCAFE_0002;

  initial begin
    rst          = 1'b1;
    bus.htrans   = T_IDLE;
    bus.haddr    = '0;
    bus.hwrite   = 1'b0;
    bus.hwdata   = '0;
    bus.hrdata_s = {D2, D1, D0};
    bus.hresp_s  = '0;
    bus.hready_s = 3'b111;
    @(posedge clk);
    #1;

    // Reset state; hsel forced low even for an active mapped address
    vec("rst_hsel",     T_NONSEQ, 16'h4000, 3'b000, 1'b1, 2'b00, 32'h0, 8'd0);
    rst = 1'b0;
    vec("idle_dec0",    T_IDLE,   16'h0000, 3'b001, 1'b1, 2'b00, 32'h0, 8'd0);

    // Zero-wait read from slave 1
    vec("s1_addr",      T_NONSEQ, 16'h4000, 3'b010, 1'b1, 2'b00, 32'h0, 8'd0);
    vec("s1_data",      T_IDLE,   16'h0000, 3'b001, 1'b1, 2'b00, D1,    8'd0);

    // Slave 2 with two wait states; next address (slave 1) held meanwhile
    vec("s2_addr",      T_NONSEQ, 16'h8000, 3'b100, 1'b1, 2'b00, 32'h0, 8'd0);
    bus.hready_s = 3'b011;
    vec("s2_wait1",     T_NONSEQ, 16'h4000, 3'b010, 1'b0, 2'b00, D2,    8'd0);
    vec("s2_wait2",     T_NONSEQ, 16'h4000, 3'b010, 1'b0, 2'b00, D2,    8'd0);
    // Slave 0 not ready must not matter to slave 2's data phase
    bus.hready_s = 3'b110;
    vec("s2_done",      T_NONSEQ, 16'h4000, 3'b010, 1'b1, 2'b00, D2,    8'd0);

    // Slave 1 ERROR completes while an unmapped NONSEQ is in address phase
    bus.hready_s = 3'b111;
    bus.hresp_s  = 6'b00_01_00;
    vec("s1_err_unmap", T_NONSEQ, 16'hC000, 3'b000, 1'b1, 2'b01, D1,    8'd0);
    bus.hresp_s  = '0;
    vec("def_err1",     T_IDLE,   16'h0000, 3'b001, 1'b0, 2'b01, 32'h0, 8'd1);
    vec("def_err2",     T_IDLE,   16'hC000, 3'b000, 1'b1, 2'b01, 32'h0, 8'd1);
    // Idle to unmapped: OKAY, no count
    vec("unmap_idle",   T_IDLE,   16'h0000, 3'b001, 1'b1, 2'b00, 32'h0, 8'd2);

    // Reset asserted during ERR1
    vec("err_addr",     T_NONSEQ, 16'hC000, 3'b000, 1'b1, 2'b00, 32'h0, 8'd2);
    rst = 1'b1;
    vec("err1_rst",     T_IDLE,   16'h0000, 3'b000, 1'b0, 2'b01, 32'h0, 8'd2);
    rst = 1'b0;
    vec("after_rst",    T_IDLE,   16'h0000, 3'b001, 1'b1, 2'b00, 32'h0, 8'd0);

    // 260 back-to-back unmapped NONSEQ transfers: counter saturates at 255
    vec("sat_first",    T_NONSEQ, 16'hC000, 3'b000, 1'b1, 2'b00, 32'h0, 8'd0);
    for (int i = 0; i < 260; i++) begin
      logic [7:0] ec;
      ec = (i > 255) ? 8'd255 : 8'(i);
      vec("sat_err1", T_NONSEQ, 16'hC000, 3'b000, 1'b0, 2'b01, 32'h0, ec);
      vec("sat_err2", (i < 259) ? T_NONSEQ : T_IDLE, 16'hC000, 3'b000, 1'b1, 2'b01, 32'h0, ec);
    end
    vec("sat_final",    T_IDLE,   16'h0000, 3'b001, 1'b1, 2'b00, 32'h0, 8'd255);
    vec("sat_hold",     T_IDLE,   16'h4000, 3'b010, 1'b1, 2'b00, 32'h0, 8'd255);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending exp 0", sbq.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
